// File: rtl/alu_nibble_sequencer.sv
// Wide-operand front end for a 4-bit combinational ALU.
// Walks operands one nibble at a time, chaining carry/borrow, and returns the wide result.
module alu_nibble_sequencer #(
  parameter  int NIBBLES = 2,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [2:0]   alu_sel,
  input  logic [3:0]   alu_result,
  input  logic         alu_carry,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_zero,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    OP,
    CIN,
    DONE
  } state_t;

  localparam logic [2:0] LAST = 3'(NIBBLES - 1);

  state_t         state;
  state_t         state_nx;
  logic [2:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2:0]     idx;
  logic [2:0]     idx_nx;
  logic           cin;
  logic           cin_nx;
  logic           c1;
  logic [W-1:0]   acc;
  logic [W-1:0]   acc_nx;
  logic [3:0]     nib_a;
  logic [3:0]     nib_b;
  logic           arith;
  logic           last;
  logic           unused_zero;

  // The ALU's own zero flag only covers one nibble.
  assign unused_zero = alu_zero;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    arith  = (op[2:1] == 2'b00);
    last   = (idx == LAST);
    idx_nx = idx + 3'd1;
    cin_nx = c1 | alu_carry;
    acc_nx = acc;
    acc_nx[{idx, 2'b00} +: 4] = alu_result;
    nib_a  = a[{idx_nx, 2'b00} +: 4];
    nib_b  = b[{idx_nx, 2'b00} +: 4];
    state_nx = state;
    unique case (state)
      IDLE: if (cmd_valid) state_nx = OP;
      OP: begin
        if (arith)     state_nx = CIN;
        else if (last) state_nx = DONE;
      end
      CIN:  state_nx = last ? DONE : OP;
      DONE: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op         <= '0;
      a          <= '0;
      b          <= '0;
      idx        <= '0;
      cin        <= 1'b0;
      c1         <= 1'b0;
      acc        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op      <= cmd_op;
            a       <= cmd_a;
            b       <= cmd_b;
            idx     <= '0;
            cin     <= 1'b0;
            c1      <= 1'b0;
            acc     <= '0;
            alu_a   <= cmd_a[3:0];
            alu_b   <= cmd_b[3:0];
            alu_sel <= cmd_op;
          end
        end
        OP: begin
          c1 <= alu_carry;
          if (arith) begin
            // Second pass folds the incoming carry/borrow into r1.
            alu_a <= alu_result;
            alu_b <= {3'b000, cin};
          end else begin
            acc <= acc_nx;
            if (last) begin
              rsp_result <= acc_nx;
              rsp_carry  <= 1'b0;
              rsp_zero   <= (acc_nx == '0);
              alu_a      <= '0;
              alu_b      <= '0;
              alu_sel    <= '0;
            end else begin
              idx   <= idx_nx;
              alu_a <= nib_a;
              alu_b <= nib_b;
            end
          end
        end
        CIN: begin
          acc <= acc_nx;
          cin <= cin_nx;
          if (last) begin
            rsp_result <= acc_nx;
            rsp_carry  <= cin_nx;
            rsp_zero   <= (acc_nx == '0);
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
          end else begin
            idx   <= idx_nx;
            alu_a <= nib_a;
            alu_b <= nib_b;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Scoreboard bench for alu_nibble_sequencer with a behavioural 4-bit ALU.
// Expected wide results come from plain W-bit arithmetic.
module tb_alu_nibble_sequencer;

  localparam int N = 2;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [2:0]   alu_sel;
  logic [3:0]   alu_result;
  logic         alu_carry;
  logic         alu_zero;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic         rsp_carry;
  logic         rsp_zero;
  logic         busy;

  alu_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .rsp_zero(rsp_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // alu4bit behaviour
  always_comb begin
    alu_carry  = 1'b0;
    alu_result = '0;
    case (alu_sel)
      3'd0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: begin
        alu_result = alu_a - alu_b;
        alu_carry  = (alu_a < alu_b);
      end
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = ~alu_a;
      3'd6: alu_result = alu_b;
      default: alu_result = alu_a;
    endcase
    alu_zero = (alu_result == 4'd0);
  end

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    int           acc_cyc;
    int           p;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(logic [2:0] op, logic [W-1:0] x, logic [W-1:0] y);
    exp_t e;
    int unsigned s;
    e.c = 1'b0;
    e.p = N;
    case (op)
      3'd0: begin
        s = int'(x) + int'(y);
        e.res = W'(s);
        e.c = (s >= (1 << W));
        e.p = 2 * N;
      end
      3'd1: begin
        e.res = W'(int'(x) - int'(y));
        e.c = (x < y);
        e.p = 2 * N;
      end
      3'd2: e.res = x & y;
      3'd3: e.res = x | y;
      3'd4: e.res = x ^ y;
      3'd5: e.res = ~x;
      3'd6: e.res = y;
      default: e.res = x;
    endcase
    e.z = (e.res == '0);
    e.acc_cyc = 0;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(logic [2:0] op, logic [W-1:0] x, logic [W-1:0] y, bit push);
    int k;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = x;
    cmd_b = y;
    k = 0;
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    e = model(op, x, y);
    e.acc_cyc = cyc + 1;
    if (push) q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom);
    cmd_a = W'($urandom);
    cmd_b = W'($urandom);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() != 0 || rsp_valid) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", k < 500, 1);
  endtask

  // Monitor: latency, hold stability, handshake compare.
  bit           seen = 1'b0;
  bit           post = 1'b0;
  logic [W-1:0] snap_r;
  logic         snap_c;
  logic         snap_z;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
      post = 1'b0;
    end else begin
      if (post) begin
        chk("ready_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
        post = 1'b0;
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 0, 1);
        end else if (!seen) begin
          chk("latency", cyc - q[0].acc_cyc, q[0].p);
          seen = 1'b1;
          snap_r = rsp_result;
          snap_c = rsp_carry;
          snap_z = rsp_zero;
        end else begin
          chk("hold_stable", {rsp_result, rsp_carry, rsp_zero},
              {snap_r, snap_c, snap_z});
          chk("hold_cmd_ready", {cmd_ready, busy}, 2'b01);
        end
      end
      rsp_ready = hold ? 1'b0 : ($urandom_range(2) != 0);
      if (rsp_valid && rsp_ready && q.size() != 0) begin
        chk("result", rsp_result, q[0].res);
        chk("carry", rsp_carry, q[0].c);
        chk("zero", rsp_zero, q[0].z);
        void'(q.pop_front());
        seen = 1'b0;
        post = 1'b1;
      end
    end
  end

  task automatic chk_reset(string nm);
    chk(nm, {cmd_ready, rsp_valid, busy, alu_a, alu_b, alu_sel,
             rsp_result, rsp_carry, rsp_zero},
        {1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, {W{1'b0}}, 1'b0, 1'b0});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    send(3'd0, 8'h7F, 8'h01, 1);
    send(3'd0, 8'hFF, 8'h01, 1);
    send(3'd1, 8'h10, 8'h01, 1);
    send(3'd1, 8'h00, 8'h01, 1);
    send(3'd4, 8'hA5, 8'hFF, 1);
    send(3'd5, 8'h0F, 8'h00, 1);
    drain();

    hold = 1'b1;
    send(3'd0, 8'h3C, 8'h4B, 1);
    repeat (8) @(negedge clk);
    hold = 1'b0;
    drain();

    send(3'd0, 8'h3C, 8'h55, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("mid_op_reset");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_rsp_after_reset", rsp_valid, 0);
    send(3'd1, 8'h5A, 8'hA5, 1);
    drain();

    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(2)) @(negedge clk);
      send(3'($urandom), W'($urandom), W'($urandom), 1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
